// File: rtl/operand_capture_pkg.sv
// operand_capture_pkg: shared types and constants for the operand capture stage.
// Holds the debounce state encoding, default parameter values and key polarity.
package operand_capture_pkg;

    // Debounce FSM states.
    // ARM and DISARM are the counting states that qualify a press or a release.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        HELD   = 2'd2,
        DISARM = 2'd3
    } state_e;

    localparam int DEF_WIDTH           = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_SYNC_STAGES     = 2;

    // The pushbutton pulls low when pressed.
    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    // True in the states where a debounced press is in effect.
    function automatic logic is_held(input state_e s);
        return (s == HELD) || (s == DISARM);
    endfunction

endpackage

// File: rtl/operand_capture_sync_ff.sv
// sync_ff: STAGES-deep multi-bit flop synchroniser, async active-low reset.
// Ports: clk_i, rst_ni, d_i[WIDTH] (async input), q_o[WIDTH] (synchronised).
module sync_ff #(
    parameter int                 WIDTH   = 1,
    parameter int                 STAGES  = 2,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/operand_capture.sv
// operand_capture: synchronise switches and key, debounce key, latch operand + load pulse.
// Ports: Clock, Reset (async low), sw[WIDTH], key (low=pressed) -> operand[WIDTH], load, held.
module operand_capture
    import operand_capture_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             key,
    output logic [WIDTH-1:0] operand,
    output logic             load,
    output logic             held
);

    // DEBOUNCE_CYCLES >= 2 keeps CW >= 1; terminal count fits without wrap.
    localparam int          CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic             key_s;
    logic [WIDTH-1:0] sw_s;

    state_e           state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic             load_q,    load_d;
    logic             held_q,    held_d;

    // Key idles released so reset never looks like a press by itself.
    sync_ff #(
        .WIDTH   (1),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (KEY_RELEASED)
    ) u_key_sync (
        .clk_i  (Clock),
        .rst_ni (Reset),
        .d_i    (key),
        .q_o    (key_s)
    );

    sync_ff #(
        .WIDTH   (WIDTH),
        .STAGES  (SYNC_STAGES),
        .RST_VAL ('0)
    ) u_sw_sync (
        .clk_i  (Clock),
        .rst_ni (Reset),
        .d_i    (sw),
        .q_o    (sw_s)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            operand_q <= '0;
            load_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            operand_q <= operand_d;
            load_q    <= load_d;
            held_q    <= held_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        operand_d = operand_q;
        load_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The first pressed sample counts as sample one.
                if (key_s == KEY_PRESSED) begin
                    state_d = ARM;
                    cnt_d   = CNT_ONE;
                end
            end
            ARM: begin
                // A release at any count, terminal included, rejects the press.
                if (key_s != KEY_PRESSED) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TERM) begin
                    state_d   = HELD;
                    cnt_d     = '0;
                    operand_d = sw_s;
                    load_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (key_s != KEY_PRESSED) begin
                    state_d = DISARM;
                    cnt_d   = CNT_ONE;
                end
            end
            DISARM: begin
                // Returning to HELD never re-issues load.
                if (key_s == KEY_PRESSED) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TERM) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Registered from the next state so held rises with load.
        held_d = is_held(state_d);
    end

    assign operand = operand_q;
    assign load    = load_q;
    assign held    = held_q;

endmodule

// File: tb/tb_operand_capture.sv
// tb_operand_capture: scenario bench for operand_capture with a load/operand scoreboard.
// DEBOUNCE_CYCLES=4, SYNC_STAGES=2; expected operands queued at stimulus time.
module tb_operand_capture;

    localparam int W  = 3;
    localparam int DB = 4;
    localparam int SS = 2;

    logic         Clock = 1'b0;
    logic         Reset = 1'b0;
    logic [W-1:0] sw    = '0;
    logic         key   = 1'b1;
    logic [W-1:0] operand;
    logic         load;
    logic         held;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_q [$];
    logic [W-1:0] obs_q [$];
    logic         prev_load = 1'b0;

    operand_capture #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SS)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .sw      (sw),
        .key     (key),
        .operand (operand),
        .load    (load),
        .held    (held)
    );

    always #5 Clock = ~Clock;

    // Collects every load pulse with its operand; also flags back-to-back loads.
    always @(negedge Clock) begin
        if (load === 1'b1) begin
            obs_q.push_back(operand);
            tests++;
            if (prev_load !== 1'b0) begin
                fails++;
                $display("FAIL load_consecutive: load high two cycles in a row at %0t", $time);
            end
        end
        prev_load = load;
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Release key and let the FSM return to IDLE.
    task automatic settle();
        key = 1'b1;
        repeat (12) step();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        key   = 1'b1;
        sw    = '0;
        #2;
        tests++;
        if (operand !== 3'b000) begin
            fails++;
            $display("FAIL reset_operand: got %b want 000", operand);
        end
        tests++;
        if (load !== 1'b0) begin
            fails++;
            $display("FAIL reset_load: got %b want 0", load);
        end
        tests++;
        if (held !== 1'b0) begin
            fails++;
            $display("FAIL reset_held: got %b want 0", held);
        end
        repeat (3) step();
        Reset = 1'b1;
        repeat (10) step();
        tests++;
        if (obs_q.size() != 0 || held !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: loads %0d held %b want 0 0", obs_q.size(), held);
        end
        obs_q.delete();
    endtask

    task automatic test_clean_press();
        logic [W-1:0] got, want;
        sw  = 3'b101;
        key = 1'b0;
        exp_q.push_back(3'b101);
        for (int k = 0; k < 10; k++) begin
            step();
            tests++;
            if (load !== (k == 5)) begin
                fails++;
                $display("FAIL clean_load edge %0d: got %b want %b", k, load, (k == 5));
            end
            tests++;
            if (held !== (k >= 5)) begin
                fails++;
                $display("FAIL clean_held edge %0d: got %b want %b", k, held, (k >= 5));
            end
        end
        repeat (50) step();
        tests++;
        if (held !== 1'b1) begin
            fails++;
            $display("FAIL clean_held_long: got %b want 1", held);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL clean_count: got %0d loads want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL clean_operand: got %b want %b", got, want);
            end
        end
        obs_q.delete();
        exp_q.delete();
        settle();
        tests++;
        if (held !== 1'b0) begin
            fails++;
            $display("FAIL clean_release: held %b want 0", held);
        end
    endtask

    task automatic test_bouncy_press();
        logic [W-1:0] got, want;
        logic         pat [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        sw = 3'b110;
        exp_q.push_back(3'b110);
        for (int k = 0; k < 16; k++) begin
            key = (k < 4) ? pat[k] : 1'b0;
            step();
            tests++;
            if (load !== (k == 9)) begin
                fails++;
                $display("FAIL bouncy_load edge %0d: got %b want %b", k, load, (k == 9));
            end
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL bouncy_count: got %0d loads want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL bouncy_operand: got %b want %b", got, want);
            end
        end
        obs_q.delete();
        exp_q.delete();
        settle();
    endtask

    task automatic test_release_bounce();
        logic [W-1:0] got, want;
        logic         pat [3] = '{1'b1, 1'b0, 1'b1};
        sw  = 3'b001;
        key = 1'b0;
        exp_q.push_back(3'b001);
        repeat (10) step();
        for (int k = 0; k < 12; k++) begin
            key = (k < 3) ? pat[k] : 1'b1;
            step();
            tests++;
            if (held !== (k < 7)) begin
                fails++;
                $display("FAIL release_held edge %0d: got %b want %b", k, held, (k < 7));
            end
        end
        sw  = 3'b011;
        key = 1'b0;
        exp_q.push_back(3'b011);
        for (int k = 0; k < 8; k++) begin
            step();
            tests++;
            if (load !== (k == 5)) begin
                fails++;
                $display("FAIL release_second_load edge %0d: got %b want %b", k, load, (k == 5));
            end
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL release_count: got %0d loads want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL release_operand: got %b want %b", got, want);
            end
        end
        obs_q.delete();
        exp_q.delete();
        settle();
    endtask

    task automatic test_switch_while_held();
        logic [W-1:0] got, want;
        sw  = 3'b010;
        key = 1'b0;
        exp_q.push_back(3'b010);
        repeat (7) step();
        sw = 3'b111;
        repeat (10) step();
        tests++;
        if (operand !== 3'b010) begin
            fails++;
            $display("FAIL sw_held_operand: got %b want 010", operand);
        end
        settle();
        tests++;
        if (operand !== 3'b010) begin
            fails++;
            $display("FAIL sw_idle_operand: got %b want 010", operand);
        end
        key = 1'b0;
        exp_q.push_back(3'b111);
        repeat (8) step();
        tests++;
        if (operand !== 3'b111) begin
            fails++;
            $display("FAIL sw_next_press: got %b want 111", operand);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL sw_count: got %0d loads want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL sw_operand: got %b want %b", got, want);
            end
        end
        obs_q.delete();
        exp_q.delete();
        settle();
    endtask

    task automatic test_async_reset();
        logic [W-1:0] got, want;
        sw  = 3'b100;
        key = 1'b0;
        repeat (4) step();
        #2;
        Reset = 1'b0;
        #1;
        tests++;
        if (load !== 1'b0 || held !== 1'b0 || operand !== 3'b000) begin
            fails++;
            $display("FAIL areset_outputs: load %b held %b operand %b want 0 0 000",
                     load, held, operand);
        end
        repeat (3) step();
        Reset = 1'b1;
        exp_q.push_back(3'b100);
        for (int k = 0; k < 12; k++) begin
            step();
            tests++;
            if (load !== (k == 5)) begin
                fails++;
                $display("FAIL areset_load edge %0d: got %b want %b", k, load, (k == 5));
            end
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL areset_count: got %0d loads want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL areset_operand: got %b want %b", got, want);
            end
        end
        obs_q.delete();
        exp_q.delete();
        settle();
    endtask

    task automatic test_terminal_bounce();
        logic [W-1:0] got, want;
        sw = 3'b011;
        for (int k = 0; k < 14; k++) begin
            key = (k < 3) ? 1'b0 : 1'b1;
            step();
            tests++;
            if (load !== 1'b0 || held !== 1'b0) begin
                fails++;
                $display("FAIL term_bounce edge %0d: load %b held %b want 0 0", k, load, held);
            end
        end
        sw  = 3'b110;
        key = 1'b0;
        exp_q.push_back(3'b110);
        for (int k = 0; k < 8; k++) begin
            step();
            tests++;
            if (load !== (k == 5)) begin
                fails++;
                $display("FAIL term_repress edge %0d: got %b want %b", k, load, (k == 5));
            end
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL term_count: got %0d loads want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL term_operand: got %b want %b", got, want);
            end
        end
        obs_q.delete();
        exp_q.delete();
        settle();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bouncy_press();
        test_release_bounce();
        test_switch_while_held();
        test_async_reset();
        test_terminal_bounce();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
